// File: rtl/ray_wall_scan.sv
`default_nettype none
// ============================================================================
// Module     : ray_wall_scan
// Description: Walks NUM_WALLS grid-line walls one per cycle and reports the
//              nearest wall ahead of a ray component (distance and index).
// Revision   : 1.0 - initial release
// ============================================================================
module ray_wall_scan #(
  parameter int NUM_WALLS  = 8,
  parameter int DIR_W      = 10,
  parameter int ORI_W      = 10,
  parameter int CELL_SHIFT = 6,
  parameter int INV_W      = DIR_W - 1,
  parameter int DIST_W     = ORI_W + INV_W
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic signed [DIR_W-1:0]                      in_dir,
  input  logic signed [ORI_W-1:0]                      in_ori,
  input  logic        [NUM_WALLS-1:0]                  in_mask,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic        [DIST_W-1:0]                     out_dist,
  output logic                                         out_hit,
  output logic        [(NUM_WALLS>1 ? $clog2(NUM_WALLS) : 1)-1:0] out_idx
);

  localparam int c_IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam int c_TAB_N = 2 ** (DIR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Round-to-nearest 2^INV_W / a; a of 0 or 1 saturates to all ones.
  function automatic logic [INV_W-1:0] inv_calc(input int unsigned a);
    longint unsigned num;
    if (a < 2) return '1;
    num = (64'd1 << (INV_W + 1)) + 64'(a);
    return INV_W'(num / (64'(a) * 64'd2));
  endfunction

  logic [INV_W-1:0] w_inv_tab [c_TAB_N];

  for (genvar g = 0; g < c_TAB_N; g++) begin : g_inv
    assign w_inv_tab[g] = inv_calc(g);
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_neg;
  logic                  r_par;
  logic [DIR_W-2:0]      r_a;
  logic signed [ORI_W-1:0] r_ori;
  logic [NUM_WALLS-1:0]  r_mask;
  logic [c_IDX_W-1:0]    r_k;
  logic [DIST_W-1:0]     r_best;
  logic                  r_hit;
  logic [c_IDX_W-1:0]    r_idx;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_par;
  logic [DIR_W-2:0]      w_abs;
  logic signed [ORI_W:0] w_wall;
  logic signed [ORI_W:0] w_ori_x;
  logic                  w_less;
  logic [ORI_W-1:0]      w_delta;
  logic [INV_W-1:0]      w_inv;
  logic [DIST_W-1:0]     w_prod;
  logic [DIST_W-1:0]     w_d;
  logic                  w_cand;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign out_dist  = r_best;
  assign out_hit   = r_hit;
  assign out_idx   = r_idx;

  // The most-negative direction has zero low bits and is treated as parallel.
  assign w_par = (in_dir[DIR_W-2:0] == '0);
  assign w_abs = in_dir[DIR_W-1] ? (~in_dir[DIR_W-2:0] + 1'b1) : in_dir[DIR_W-2:0];

  assign w_wall  = $signed({{(ORI_W+1-c_IDX_W){1'b0}}, r_k} << CELL_SHIFT);
  assign w_ori_x = {r_ori[ORI_W-1], r_ori};
  assign w_less  = (w_wall < w_ori_x);
  assign w_delta = w_less ? ORI_W'(w_ori_x - w_wall) : ORI_W'(w_wall - w_ori_x);
  assign w_inv   = w_inv_tab[r_a];
  assign w_prod  = DIST_W'(w_delta) * DIST_W'(w_inv);
  assign w_d     = w_prod >> 1;
  assign w_cand  = r_mask[r_k] && !r_par && (r_neg == w_less);
  assign w_last  = (r_k == c_IDX_W'(NUM_WALLS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg  <= 1'b0;
      r_par  <= 1'b1;
      r_a    <= '0;
      r_ori  <= '0;
      r_mask <= '0;
      r_k    <= '0;
      r_best <= '1;
      r_hit  <= 1'b0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_neg  <= in_dir[DIR_W-1];
      r_par  <= w_par;
      r_a    <= w_abs;
      r_ori  <= in_ori;
      r_mask <= in_mask;
      r_k    <= '0;
      r_best <= '1;
      r_hit  <= 1'b0;
      r_idx  <= '0;
    end else if (r_state == S_SCAN) begin
      r_k <= r_k + 1'b1;
      // Strict compare keeps the lower index on ties.
      if (w_cand && (w_d < r_best)) begin
        r_best <= w_d;
        r_hit  <= 1'b1;
        r_idx  <= r_k;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ray_wall_scan.sv
`default_nettype none
// ============================================================================
// Module     : tb_ray_wall_scan
// Description: Directed and random requests against an arithmetic model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ray_wall_scan;

  localparam int NW  = 8;
  localparam int DW  = 10;
  localparam int OW  = 10;
  localparam int DSW = 19;
  localparam int XW  = 3;
  localparam logic [DSW-1:0] MISS_D = 19'h7FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dir = '0;
  logic [OW-1:0] in_ori = '0;
  logic [NW-1:0] in_mask = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DSW-1:0] out_dist;
  logic          out_hit;
  logic [XW-1:0] out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ray_wall_scan #(
    .NUM_WALLS(NW), .DIR_W(DW), .ORI_W(OW), .CELL_SHIFT(6)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dir(in_dir), .in_ori(in_ori), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dist(out_dist), .out_hit(out_hit), .out_idx(out_idx)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Nearest wall ahead of the ray, straight from the geometric rules.
  task automatic model(input int dir, input int ori, input logic [NW-1:0] mask,
                       output logic [DSW-1:0] d, output logic h, output logic [XW-1:0] idx);
    longint best, dd, delta, inv;
    int a, w;
    bit par;
    best = 0; h = 1'b0; idx = '0;
    par = (dir == 0) || (dir == -512);
    a = (dir < 0) ? -dir : dir;
    inv = (a < 2) ? 511 : longint'($rtoi(512.0 / a + 0.5));
    for (int k = 0; k < NW; k++) begin
      w = k * 64;
      if (mask[k] && !par && ((dir < 0) == (w < ori))) begin
        delta = (w > ori) ? longint'(w - ori) : longint'(ori - w);
        dd = (delta * inv) / 2;
        if (!h || dd < best) begin
          best = dd; h = 1'b1; idx = XW'(k);
        end
      end
    end
    d = h ? DSW'(best) : MISS_D;
  endtask

  task automatic run_req(input int dir, input int ori, input logic [NW-1:0] mask,
                         input int hold, input string tag);
    logic [DSW-1:0] ed;
    logic eh;
    logic [XW-1:0] ei;
    int lat, wt;
    model(dir, ori, mask, ed, eh, ei);
    wt = 0;
    while (!in_ready && wt < 20) begin @(posedge clk); #1; wt++; end
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_dir = DW'(dir); in_ori = OW'(ori); in_mask = mask; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_dir = DW'($urandom); in_ori = OW'($urandom); in_mask = NW'($urandom);
    lat = 1;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_dist"}, 64'(out_dist), 64'(ed));
    check({tag, "_hit"}, 64'(out_hit), 64'(eh));
    check({tag, "_idx"}, 64'(out_idx), 64'(ei));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_dir = DW'($urandom); in_ori = OW'($urandom); in_mask = NW'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_v"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_d"}, 64'(out_dist), 64'(ed));
      check({tag, "_hold_i"}, 64'({out_hit, out_idx}), 64'({eh, ei}));
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, "_post_v"}, 64'(out_valid), 64'd0);
    check({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen, dir, ori;
    logic [NW-1:0] msk;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_dist", 64'(out_dist), 64'(MISS_D));
    check("rst_hit", 64'(out_hit), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_rel_rdy", 64'(in_ready), 64'd1);

    run_req(256, 100, 8'b0000_0100, 0, "fwd");
    run_req(-128, 200, 8'b0001_0110, 1, "bwd");
    run_req(64, 192, 8'b0000_1000, 0, "at_ori_pos");
    run_req(-64, 192, 8'b0000_1000, 0, "at_ori_neg");
    run_req(0, 37, 8'hFF, 0, "par_zero");
    run_req(-512, -300, 8'hFF, 0, "par_min");
    run_req(1, 0, 8'b0000_0010, 0, "shallow");
    run_req(-1, 500, 8'hFF, 2, "shallow_neg");
    run_req(3, -500, 8'b1000_0001, 0, "far");
    run_req(200, 64, 8'b0000_0110, 5, "bp");

    // Reset while the scan sits at wall 3.
    in_dir = DW'(100); in_ori = OW'(-50); in_mask = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_rdy_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_rdy", 64'(in_ready), 64'd1);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_dist", 64'(out_dist), 64'(MISS_D));
    check("midrst_hit", 64'(out_hit), 64'd0);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    check("midrst_no_result", 64'(seen), 64'd0);
    run_req(-300, 400, 8'b0011_1100, 0, "after_rst");

    for (int n = 0; n < 24; n++) begin
      dir = int'($urandom_range(0, 1023)) - 512;
      if ($urandom_range(0, 3) == 0) dir = int'($urandom_range(0, 4)) - 2;
      ori = int'($urandom_range(0, 1023)) - 512;
      if ($urandom_range(0, 3) == 0) ori = int'($urandom_range(0, 7)) * 64;
      msk = NW'($urandom);
      run_req(dir, ori, msk, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
